// File: rtl/sag_pkg.sv
// Shared definitions for the SAG round-robin scheduler.
//   - op field bit positions inside a requester's 3-bit op code {rt,inv,nr}
//   - scheduler FSM state encoding
//   - round-robin pointer advance helper
package sag_pkg;

    localparam int OP_NR  = 0;   // non-reversing variant: zero-mask bits keep ascending order
    localparam int OP_INV = 1;   // inverse (un-gather) direction
    localparam int OP_RT  = 2;   // round-trip self-check: forward pass then inverse pass
    localparam int OPW    = 3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PASS2 = 1'b1
    } state_t;

    // Index of the requester that gets top priority after `idx` was granted.
    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1) % nreq;
    endfunction

endpackage

// File: rtl/paramNrInvSag.sv
// Combinational sheep-and-goats (SAG) permutation core.
//   Forward (inv=0): bits of di whose ci bit is 1 are packed, in ascending
//   order, into the low popcount(ci) result bits. Bits whose ci bit is 0 fill
//   the remaining high bits: with nr=0 the lowest such bit lands in the MSB
//   (reversed order), with nr=1 they keep ascending order above the packed field.
//   Inverse (inv=1): exact inverse of the forward permutation for the same ci/nr.
//   FORCE_NR / FORCE_INV: -1 uses the nr/inv inputs, 0 or 1 ties the mode.
// Ports:
//   di   in  N  data operand
//   ci   in  N  control mask
//   nr   in  1  non-reversing mode
//   inv  in  1  inverse direction
//   res  out N  permuted data
module paramNrInvSag #(
    parameter int LOG2N     = 3,
    parameter int FORCE_NR  = -1,
    parameter int FORCE_INV = -1
) (
    input  logic [(1<<LOG2N)-1:0] di,
    input  logic [(1<<LOG2N)-1:0] ci,
    input  logic                  nr,
    input  logic                  inv,
    output logic [(1<<LOG2N)-1:0] res
);

    localparam int N  = 1 << LOG2N;
    localparam int CW = LOG2N + 1;   // counters must hold N itself

    logic          nr_eff;
    logic          inv_eff;
    logic [CW-1:0] k;                // number of mask-1 bits
    logic [CW-1:0] n1;               // mask-1 bits seen so far
    logic [CW-1:0] n0;               // mask-0 bits seen so far
    logic [CW-1:0] pos;              // result position paired with source bit i

    assign nr_eff  = (FORCE_NR  < 0) ? nr  : (FORCE_NR  != 0);
    assign inv_eff = (FORCE_INV < 0) ? inv : (FORCE_INV != 0);

    // NOTE: blocking assignments here are deliberate: the counters carry a
    // value from one loop iteration to the next within a single evaluation,
    // and every variable gets a default first so no latch is inferred.
    always_comb begin
        res = '0;
        k   = '0;
        n1  = '0;
        n0  = '0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            k = k + CW'(ci[i]);
        end
        for (int i = 0; i < N; i++) begin
            if (ci[i]) begin
                pos = n1;
                n1  = n1 + CW'(1);
            end else begin
                pos = nr_eff ? (k + n0) : (CW'(N - 1) - n0);
                n0  = n0 + CW'(1);
            end
            // Source i and position pos form one pair of the permutation;
            // the direction flag only decides which side is read.
            if (inv_eff) begin
                res[i] = di[pos[LOG2N-1:0]];
            end else begin
                res[pos[LOG2N-1:0]] = di[i];
            end
        end
    end

endmodule

// File: rtl/sag_rr_arbiter.sv
// NREQ-way round-robin arbiter.
//   Grants the first asserted req at or after ptr, wrapping circularly.
//   Nothing is granted while en is low.
// Ports:
//   req      in  NREQ          request vector
//   ptr      in  $clog2(NREQ)  highest-priority index this cycle
//   en       in  1             grant enable
//   gnt      out NREQ          one-hot grant (all zero when nothing granted)
//   gnt_idx  out $clog2(NREQ)  index of the granted requester (0 when none)
module sag_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IDW = $clog2(NREQ);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = IDW'((int'(ptr) + off) % NREQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/sag_rr_scheduler.sv
// Round-robin scheduler sharing one SAG core between NREQ requesters.
//   Plain ops finish in the grant cycle and are registered into a single
//   output slot (latency 1). Round-trip ops run the core twice: forward at
//   grant, inverse in PASS2; the result and a mismatch flag go to the slot.
// Ports:
//   clk        in  1              rising-edge clock
//   rst        in  1              synchronous active-high reset
//   req_valid  in  NREQ           request valid per requester
//   req_ready  out NREQ           one-hot accept, combinational
//   req_di     in  NREQ*N         data operands, slice r = requester r
//   req_ci     in  NREQ*N         control masks
//   req_op     in  NREQ*3         {rt,inv,nr} per requester
//   req_tag    in  NREQ*TAGW      opaque tags
//   rsp_valid  out 1              result valid
//   rsp_ready  in  1              downstream accepts result
//   rsp_do     out N              result data
//   rsp_id     out $clog2(NREQ)   owning requester
//   rsp_tag    out TAGW           echoed tag
//   rsp_err    out 1              round-trip mismatch (0 for plain ops)
//   busy       out 1              PASS2 in progress or result pending
module sag_rr_scheduler
    import sag_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int NREQ  = 2,
    parameter int TAGW  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*(1<<LOG2N)-1:0]   req_di,
    input  logic [NREQ*(1<<LOG2N)-1:0]   req_ci,
    input  logic [NREQ*3-1:0]            req_op,
    input  logic [NREQ*TAGW-1:0]         req_tag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [(1<<LOG2N)-1:0]        rsp_do,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [TAGW-1:0]              rsp_tag,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int N   = 1 << LOG2N;
    localparam int IDW = $clog2(NREQ);

    state_t          state;
    state_t          state_n;
    logic [IDW-1:0]  ptr;

    logic            slot_free;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;

    // Payload of the granted requester
    logic [N-1:0]    g_di;
    logic [N-1:0]    g_ci;
    logic [OPW-1:0]  g_op;
    logic [TAGW-1:0] g_tag;

    // Operands held across a round-trip op
    logic [N-1:0]    p_mid;
    logic [N-1:0]    p_ci;
    logic [N-1:0]    p_di;
    logic            p_nr;
    logic            p_inv;
    logic [TAGW-1:0] p_tag;
    logic [IDW-1:0]  p_id;

    // Shared core
    logic [N-1:0]    core_di;
    logic [N-1:0]    core_ci;
    logic            core_nr;
    logic            core_inv;
    logic [N-1:0]    core_res;

    logic            load_direct;
    logic            load_fin;
    logic            latch_rt;

    // A result can be written when the slot is empty or drains this cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    assign arb_en    = (state == S_IDLE) && slot_free;

    sag_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    assign g_di  = req_di [gnt_idx*N    +: N];
    assign g_ci  = req_ci [gnt_idx*N    +: N];
    assign g_op  = req_op [gnt_idx*OPW  +: OPW];
    assign g_tag = req_tag[gnt_idx*TAGW +: TAGW];

    paramNrInvSag #(
        .LOG2N     (LOG2N),
        .FORCE_NR  (-1),
        .FORCE_INV (-1)
    ) u_core (
        .di  (core_di),
        .ci  (core_ci),
        .nr  (core_nr),
        .inv (core_inv),
        .res (core_res)
    );

    // Next state, core input mux and slot/latch strobes.
    always_comb begin
        state_n     = state;
        load_direct = 1'b0;
        load_fin    = 1'b0;
        latch_rt    = 1'b0;
        core_di     = g_di;
        core_ci     = g_ci;
        core_nr     = g_op[OP_NR];
        core_inv    = g_op[OP_INV];
        case (state)
            S_IDLE: begin
                if (|gnt) begin
                    if (g_op[OP_RT]) begin
                        latch_rt = 1'b1;
                        state_n  = S_PASS2;
                    end else begin
                        load_direct = 1'b1;
                    end
                end
            end
            S_PASS2: begin
                // Second pass undoes the first: same mask and mode, flipped direction.
                core_di  = p_mid;
                core_ci  = p_ci;
                core_nr  = p_nr;
                core_inv = ~p_inv;
                if (slot_free) begin
                    load_fin = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Round-robin pointer and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_do    <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (|gnt) begin
                ptr <= IDW'(rr_next(int'(gnt_idx), NREQ));
            end
            if (load_direct) begin
                rsp_valid <= 1'b1;
                rsp_do    <= core_res;
                rsp_id    <= gnt_idx;
                rsp_tag   <= g_tag;
                rsp_err   <= 1'b0;
            end else if (load_fin) begin
                rsp_valid <= 1'b1;
                rsp_do    <= core_res;
                rsp_id    <= p_id;
                rsp_tag   <= p_tag;
                rsp_err   <= (core_res != p_di);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // NOTE: these operand holders are not reset: they are always written at
    // the grant that enters PASS2 and are read only in PASS2, which reset
    // leaves unreachable until the next such grant.
    always_ff @(posedge clk) begin
        if (latch_rt) begin
            p_mid <= core_res;
            p_ci  <= g_ci;
            p_di  <= g_di;
            p_nr  <= g_op[OP_NR];
            p_inv <= g_op[OP_INV];
            p_tag <= g_tag;
            p_id  <= gnt_idx;
        end
    end

    assign busy = (state != S_IDLE) || rsp_valid;

endmodule
